// File: rtl/l2_rr_arbiter_pkg.sv
// Shared types for the L2 round-robin arbiter: FSM state encoding and the
// grant-index width helper.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/l2_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index strictly after
// last_grant, wrapping modulo NUM_PORTS.
module rr_pick #(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = 1
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     last_grant,
   output logic [IDX_W-1:0]     winner,
   output logic                 any_req
);

   int idx;

   // Walk from the farthest offset down so the nearest requester overwrites last.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         idx = (int'(last_grant) + i) % NUM_PORTS;
         if (req[idx]) begin
            winner  = IDX_W'(idx);
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/l2_rr_arbiter.sv
// N-port round-robin arbiter in front of the shared L2 port.
// Define ARB_RESP_REG_EN to register the L2 read data and response (adds RESP).
module l2_rr_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int LINE_W    = 256
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        port_read,
   input  logic [NUM_PORTS-1:0]        port_write,
   input  logic [NUM_PORTS*ADDR_W-1:0] port_address,
   input  logic [NUM_PORTS*LINE_W-1:0] port_wdata,
   output logic [NUM_PORTS-1:0]        port_resp,
   output logic [LINE_W-1:0]           port_rdata,
   output logic                        l2_read,
   output logic                        l2_write,
   output logic [ADDR_W-1:0]           l2_address,
   output logic [LINE_W-1:0]           l2_wdata,
   input  logic                        l2_resp,
   input  logic [LINE_W-1:0]           l2_rdata
);

   localparam int IDX_W = idx_w(NUM_PORTS);

   arb_state_e           state;
   logic [IDX_W-1:0]     grant;
   logic [IDX_W-1:0]     last_grant;
   logic [IDX_W-1:0]     winner;
   logic                 any_req;
   logic [NUM_PORTS-1:0] req_vec;
   logic [NUM_PORTS-1:0] grant_oh;

   assign req_vec  = port_read | port_write;
   assign grant_oh = NUM_PORTS'(1) << grant;

   rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_pick (
      .req        (req_vec),
      .last_grant (last_grant),
      .winner     (winner),
      .any_req    (any_req)
   );

`ifdef ARB_RESP_REG_EN
   logic [LINE_W-1:0] rdata_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= IDX_W'(NUM_PORTS - 1);
         l2_read    <= 1'b0;
         l2_write   <= 1'b0;
         l2_address <= '0;
         l2_wdata   <= '0;
`ifdef ARB_RESP_REG_EN
         rdata_q    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant      <= winner;
                  last_grant <= winner;
                  // A port raising both read and write is served as a write.
                  l2_write   <= port_write[winner];
                  l2_read    <= port_read[winner] & ~port_write[winner];
                  l2_address <= port_address[int'(winner)*ADDR_W +: ADDR_W];
                  l2_wdata   <= port_wdata[int'(winner)*LINE_W +: LINE_W];
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (l2_resp) begin
                  l2_read  <= 1'b0;
                  l2_write <= 1'b0;
`ifdef ARB_RESP_REG_EN
                  rdata_q  <= l2_rdata;
                  state    <= RESP;
`else
                  state    <= IDLE;
`endif
               end
            end
`ifdef ARB_RESP_REG_EN
            RESP:    state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ARB_RESP_REG_EN
   always_comb begin
      port_resp  = (state == RESP) ? grant_oh : '0;
      port_rdata = rdata_q;
   end
`else
   logic resp_fire;
   assign resp_fire = (state == BUSY) & l2_resp;

   // Response path is combinational from L2 and gated so it reads zero otherwise.
   always_comb begin
      port_resp  = resp_fire ? grant_oh : '0;
      port_rdata = resp_fire ? l2_rdata : '0;
   end
`endif

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Scoreboard bench for l2_rr_arbiter: randomized request batches, a behavioural
// L2 responder and a round-robin reference model.
module tb_l2_rr_arbiter;

   localparam int NP = 4;
   localparam int AW = 32;
   localparam int LW = 256;
`ifdef ARB_RESP_REG_EN
   localparam int M = 1;
`else
   localparam int M = 0;
`endif

   typedef struct {
      int            port;
      bit            wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      bit            first;
      int            launch;
   } txn_t;

   typedef struct {
      int            port;
      bit            wr;
      logic [LW-1:0] rdata;
      int            cyc;
   } rsp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NP-1:0]    port_read, port_write, port_resp;
   logic [NP*AW-1:0] port_address;
   logic [NP*LW-1:0] port_wdata;
   logic [LW-1:0]    port_rdata, l2_wdata, l2_rdata;
   logic             l2_read, l2_write, l2_resp;
   logic [AW-1:0]    l2_address;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   model_last;
   int   last_resp_cyc;
   int   cur_port;
   bit   cur_vld;
   bit   hold_resp;
   bit   quiet;
   txn_t exp_q[$];
   rsp_t rsp_q[$];
   logic [AW-1:0] addr_a[NP];
   logic [LW-1:0] wd_a[NP];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   l2_rr_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .port_read(port_read), .port_write(port_write),
      .port_address(port_address), .port_wdata(port_wdata),
      .port_resp(port_resp), .port_rdata(port_rdata),
      .l2_read(l2_read), .l2_write(l2_write),
      .l2_address(l2_address), .l2_wdata(l2_wdata),
      .l2_resp(l2_resp), .l2_rdata(l2_rdata)
   );

   task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] rnd_line();
      logic [LW-1:0] r;
      r = '0;
      for (int i = 0; i < LW / 32; i++) r = {r[LW-33:0], $urandom};
      return r;
   endfunction

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_port_resp"}, port_resp, 0);
      chk({tag, "_l2_read"}, l2_read, 0);
      chk({tag, "_l2_write"}, l2_write, 0);
      chk({tag, "_l2_address"}, l2_address, 0);
      chk({tag, "_l2_wdata"}, l2_wdata, 0);
      chk({tag, "_port_rdata"}, port_rdata, 0);
   endtask

   // Reference order: repeatedly take the first pending port after the last grant.
   task automatic run_batch(input logic [NP-1:0] rd, input logic [NP-1:0] wr);
      logic [NP-1:0] rem, pend;
      bit            first;
      int            t;
      txn_t          e;
      rem   = rd | wr;
      first = 1'b1;
      while (rem != 0) begin
         for (int k = 1; k <= NP; k++) begin
            int p;
            p = (model_last + k) % NP;
            if (rem[p]) begin
               e.port = p; e.wr = wr[p]; e.addr = addr_a[p]; e.wdata = wd_a[p];
               e.first = first; e.launch = cyc;
               exp_q.push_back(e);
               first = 1'b0;
               rem[p] = 1'b0;
               model_last = p;
               break;
            end
         end
      end
      for (int i = 0; i < NP; i++) begin
         if (rd[i] | wr[i]) begin
            port_address[i*AW +: AW] = addr_a[i];
            port_wdata[i*LW +: LW]   = wd_a[i];
            port_read[i]  = rd[i];
            port_write[i] = wr[i];
         end
      end
      pend = rd | wr;
      t = 0;
      while (pend != 0 && t < 300) begin
         @(negedge clk);
         t++;
         for (int i = 0; i < NP; i++) begin
            if (port_resp[i]) begin
               port_read[i] = 1'b0; port_write[i] = 1'b0; pend[i] = 1'b0;
            end
         end
         if (cur_vld && pend[cur_port]) begin
            port_wdata[cur_port*LW +: LW]   = rnd_line();
            port_address[cur_port*AW +: AW] = $urandom;
         end
      end
      if (pend != 0) begin
         checks++; errors++;
         $display("FAIL batch_timeout pending %b exp 0", pend);
         port_read = '0; port_write = '0;
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
   endtask

   // Behavioural L2: checks each command against the scoreboard, then replies.
   initial begin
      txn_t e;
      bit   have;
      int   n, dly, exp_start;
      l2_resp = 1'b0; l2_rdata = '0; cur_vld = 1'b0; cur_port = 0; last_resp_cyc = 0;
      forever begin
         @(negedge clk);
         if (rst_n && (l2_read || l2_write)) begin
            have = (exp_q.size() != 0);
            if (have) begin
               e = exp_q.pop_front();
               exp_start = e.first ? e.launch + 1 : last_resp_cyc + 2 + M;
               chk("grant_cycle", cyc, exp_start);
               chk("l2_write", l2_write, e.wr);
               chk("l2_read", l2_read, !e.wr);
               chk("l2_address", l2_address, e.addr);
               chk("l2_wdata", l2_wdata, e.wdata);
               cur_port = e.port;
               cur_vld  = 1'b1;
            end else begin
               checks++; errors++;
               $display("FAIL unexpected_grant l2_address %h exp none", l2_address);
            end
            dly = $urandom_range(1, 6);
            n = 0;
            while ((n < dly || hold_resp) && rst_n) begin
               @(posedge clk); #1;
               n++;
            end
            cur_vld = 1'b0;
            if (rst_n) begin
               if (have) begin
                  chk("held_address", l2_address, e.addr);
                  chk("held_wdata", l2_wdata, e.wdata);
               end
               l2_rdata = rnd_line();
               l2_resp  = 1'b1;
               last_resp_cyc = cyc;
               if (have) rsp_q.push_back('{e.port, e.wr, l2_rdata, cyc});
               @(posedge clk); #1;
               l2_resp  = 1'b0;
               l2_rdata = rnd_line();
               if (have) chk("cmd_dropped", {l2_read, l2_write}, 0);
            end
         end else if (quiet && !l2_read && !l2_write) begin
            l2_resp  = 1'b1;
            l2_rdata = rnd_line();
            @(negedge clk);
            l2_resp  = 1'b0;
         end
      end
   end

   // Response monitor.
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (port_resp != 0) begin
            if (rsp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_port_resp got %b exp 0", port_resp);
            end else begin
               r = rsp_q.pop_front();
               chk("port_resp", port_resp, 4'(1) << r.port);
               chk("resp_cycle", cyc, r.cyc + M);
               if (!r.wr) chk("port_rdata", port_rdata, r.rdata);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NP-1:0] rd, wr;
      rst_n = 1'b0; port_read = '0; port_write = '0; port_address = '0; port_wdata = '0;
      quiet = 1'b0; hold_resp = 1'b0; model_last = NP - 1;
      for (int i = 0; i < NP; i++) begin addr_a[i] = $urandom; wd_a[i] = rnd_line(); end
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Simultaneous ports 0 and 3, twice: 0 first each time.
      addr_a[0] = 32'h0000_0100; addr_a[3] = 32'h0000_0300;
      run_batch(4'b1001, 4'b0000);
      run_batch(4'b1001, 4'b0000);
      // All four held: 0,1,2,3.
      for (int i = 0; i < NP; i++) addr_a[i] = 32'h0000_2000 + 32'(i * 64);
      run_batch(4'b1111, 4'b0000);
      // Single read from port 2.
      addr_a[2] = 32'h0000_1040;
      run_batch(4'b0100, 4'b0000);
      // Write from port 1; its wdata is scrambled while BUSY.
      addr_a[1] = 32'h8000_0000;
      wd_a[1]   = {8{32'h1234_5678}};
      run_batch(4'b0000, 4'b0010);
      // Port 3 raising both read and write is served as a write.
      run_batch(4'b1000, 4'b1000);

      // Stray l2_resp while idle must be ignored.
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("idle_port_resp", port_resp, 0);
         chk("idle_l2_cmd", {l2_read, l2_write}, 0);
      end
      quiet = 1'b0;
      repeat (3) @(negedge clk);

      // Reset two cycles into a read.
      hold_resp = 1'b1;
      addr_a[2] = 32'h0000_5000;
      exp_q.push_back('{2, 1'b0, addr_a[2], wd_a[2], 1'b1, cyc});
      port_address[2*AW +: AW] = addr_a[2];
      port_wdata[2*LW +: LW]   = wd_a[2];
      port_read[2] = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("mid_busy_reset");
      port_read = '0; port_write = '0;
      exp_q.delete(); rsp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold_resp = 1'b0;
      model_last = NP - 1;
      @(negedge clk);
      run_batch(4'b0101, 4'b0000);

      for (int b = 0; b < 40; b++) begin
         rd = 4'($urandom);
         wr = 4'($urandom) & 4'($urandom);
         if ((rd | wr) == 0) rd[$urandom_range(0, NP-1)] = 1'b1;
         for (int i = 0; i < NP; i++) begin addr_a[i] = $urandom; wd_a[i] = rnd_line(); end
         run_batch(rd, wr);
      end

      repeat (10) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
